// File: rtl/wallace_mult_pipe_if.sv
// Operand/result bundle between the execute-stage operand latches (master)
// and the pipelined Wallace multiplier (slave).
interface wallace_mult_pipe_if #(
  parameter int WIDTH = 32
);
  logic                 ctrl_MULT;
  logic                 ctrl_signed;
  logic [WIDTH-1:0]     data_operandA;
  logic [WIDTH-1:0]     data_operandB;
  logic [2*WIDTH-1:0]   data_product;
  logic [WIDTH-1:0]     data_result;
  logic                 data_exception;
  logic                 data_resultRDY;

  modport master (
    output ctrl_MULT,
    output ctrl_signed,
    output data_operandA,
    output data_operandB,
    input  data_product,
    input  data_result,
    input  data_exception,
    input  data_resultRDY
  );

  modport slave (
    input  ctrl_MULT,
    input  ctrl_signed,
    input  data_operandA,
    input  data_operandB,
    output data_product,
    output data_result,
    output data_exception,
    output data_resultRDY
  );
endinterface

// File: rtl/wallace_mult_pipe.sv
// Pipelined WIDTH x WIDTH Wallace-tree multiplier, signed (Baugh-Wooley) or
// unsigned per operation. One issue per cycle, no stalls; the result is
// visible three edges after the issue edge.
//
// Pipeline:
//   issue edge : operands, mode and valid captured
//   +1 edge    : partial products reduced by 3:2 layers, sum/carry captured
//   +2 edge    : low half of the carry-propagate add captured with its carry
//   +3 edge    : high half added, product / result / overflow / ready captured
// The final 2*WIDTH-bit add is split over two edges so the long carry chain
// does not sit behind the reduction tree in a single cycle.
module wallace_mult_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  wallace_mult_pipe_if.slave bus
);

  localparam int P = 2 * WIDTH;

  // Rows left after one layer: every group of three rows becomes a sum row
  // and a carry row; the one or two leftover rows pass straight through.
  function automatic int next_rows(input int n);
    return (n / 3) * 2 + (n % 3);
  endfunction

  // Number of 3:2 layers needed to bring n rows down to two.
  function automatic int num_levels(input int n);
    int r;
    int l;
    r = n;
    l = 0;
    while (r > 2) begin
      r = next_rows(r);
      l = l + 1;
    end
    return l;
  endfunction

  // Row count entering layer lvl.
  function automatic int rows_at(input int n, input int lvl);
    int r;
    r = n;
    for (int k = 0; k < lvl; k++) begin
      r = next_rows(r);
    end
    return r;
  endfunction

  localparam int NLEV = num_levels(WIDTH);

  // ------------------------------------------------------------------
  // Stage 1: operand capture
  // ------------------------------------------------------------------
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             signed_s1_reg;
  logic             valid_s1_reg;

  // Capture operands every cycle; only the valid bit follows the issue strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_reg         <= '0;
      b_reg         <= '0;
      signed_s1_reg <= 1'b0;
      valid_s1_reg  <= 1'b0;
    end else begin
      a_reg         <= bus.data_operandA;
      b_reg         <= bus.data_operandB;
      signed_s1_reg <= bus.ctrl_signed;
      valid_s1_reg  <= bus.ctrl_MULT;
    end
  end

  // ------------------------------------------------------------------
  // Partial products and Wallace reduction (combinational, stage 1 -> 2)
  // ------------------------------------------------------------------
  // tree[l][r] is row r entering layer l; tree[NLEV][0..1] are the final
  // sum and carry rows. Slots beyond a layer's row count are tied to zero.
  logic [P-1:0] tree [0:NLEV][0:WIDTH-1];

  // Baugh-Wooley correction constants: 1s at columns WIDTH and 2*WIDTH-1.
  // Row 0 only occupies columns 0..WIDTH-1, so both constants fit in it.
  logic [P-1:0] bw_const;
  assign bw_const = {signed_s1_reg, {(P-WIDTH-2){1'b0}}, signed_s1_reg, {WIDTH{1'b0}}};

  genvar gi, gj;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_pp
      // In signed mode the MSB row inverts all but its own MSB term, and
      // every other row inverts its MSB-column term.
      localparam logic [WIDTH-1:0] INV_MASK = (gi == WIDTH-1) ?
          {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
      logic [WIDTH-1:0] pp_bits;
      assign pp_bits = (a_reg & {WIDTH{b_reg[gi]}}) ^ (INV_MASK & {WIDTH{signed_s1_reg}});
      if (gi == 0) begin : g_row0
        assign tree[0][gi] = ({{WIDTH{1'b0}}, pp_bits} << gi) | bw_const;
      end else begin : g_rowi
        assign tree[0][gi] = ({{WIDTH{1'b0}}, pp_bits} << gi);
      end
    end

    for (gi = 0; gi < NLEV; gi++) begin : g_lvl
      localparam int N_IN  = rows_at(WIDTH, gi);
      localparam int N_GRP = N_IN / 3;
      localparam int N_OUT = next_rows(N_IN);

      // Full-adder layer: each triple of rows becomes a sum row and a carry
      // row shifted one column left (bits past 2*WIDTH-1 drop, arithmetic
      // is modulo 2^(2*WIDTH)).
      for (gj = 0; gj < N_GRP; gj++) begin : g_fa
        logic [P-1:0] x;
        logic [P-1:0] y;
        logic [P-1:0] z;
        assign x = tree[gi][3*gj];
        assign y = tree[gi][3*gj+1];
        assign z = tree[gi][3*gj+2];
        assign tree[gi+1][2*gj]   = x ^ y ^ z;
        assign tree[gi+1][2*gj+1] = ((x & y) | (x & z) | (y & z)) << 1;
      end

      // Leftover rows (one or two) ride along to the next layer unchanged.
      for (gj = 0; gj < N_IN - 3*N_GRP; gj++) begin : g_pass
        assign tree[gi+1][2*N_GRP+gj] = tree[gi][3*N_GRP+gj];
      end

      for (gj = N_OUT; gj < WIDTH; gj++) begin : g_zero
        assign tree[gi+1][gj] = '0;
      end
    end
  endgenerate

  // ------------------------------------------------------------------
  // Stage 2: sum / carry capture
  // ------------------------------------------------------------------
  logic [P-1:0] sum_reg;
  logic [P-1:0] carry_reg;
  logic         signed_s2_reg;
  logic         valid_s2_reg;

  // Register the two remaining rows of the tree with the mode and valid bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      sum_reg       <= '0;
      carry_reg     <= '0;
      signed_s2_reg <= 1'b0;
      valid_s2_reg  <= 1'b0;
    end else begin
      sum_reg       <= tree[NLEV][0];
      carry_reg     <= tree[NLEV][1];
      signed_s2_reg <= signed_s1_reg;
      valid_s2_reg  <= valid_s1_reg;
    end
  end

  // ------------------------------------------------------------------
  // Stage 3a: low half of the carry-propagate add
  // ------------------------------------------------------------------
  logic [WIDTH:0]   lo_add;
  logic [WIDTH-1:0] lo_reg;
  logic             lo_carry_reg;
  logic [WIDTH-1:0] hi_sum_reg;
  logic [WIDTH-1:0] hi_carry_reg;
  logic             signed_s3_reg;
  logic             valid_s3_reg;

  assign lo_add = {1'b0, sum_reg[WIDTH-1:0]} + {1'b0, carry_reg[WIDTH-1:0]};

  // Keep the finished low half and its carry-out; the high halves wait a cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      lo_reg        <= '0;
      lo_carry_reg  <= 1'b0;
      hi_sum_reg    <= '0;
      hi_carry_reg  <= '0;
      signed_s3_reg <= 1'b0;
      valid_s3_reg  <= 1'b0;
    end else begin
      lo_reg        <= lo_add[WIDTH-1:0];
      lo_carry_reg  <= lo_add[WIDTH];
      hi_sum_reg    <= sum_reg[P-1:WIDTH];
      hi_carry_reg  <= carry_reg[P-1:WIDTH];
      signed_s3_reg <= signed_s2_reg;
      valid_s3_reg  <= valid_s2_reg;
    end
  end

  // ------------------------------------------------------------------
  // Stage 3b: high half, overflow detection, output registers
  // ------------------------------------------------------------------
  logic [WIDTH-1:0] hi_add;
  logic [P-1:0]     product_next;
  logic [WIDTH:0]   upper_signed;
  logic             exception_next;

  assign hi_add       = hi_sum_reg + hi_carry_reg + {{(WIDTH-1){1'b0}}, lo_carry_reg};
  assign product_next = {hi_add, lo_reg};
  assign upper_signed = product_next[P-1:WIDTH-1];

  // Signed: bits above the result's sign bit must all copy it.
  // Unsigned: the whole upper half must be zero.
  assign exception_next = signed_s3_reg ? ((|upper_signed) & ~(&upper_signed))
                                        : (|product_next[P-1:WIDTH]);

  logic [P-1:0] product_reg;
  logic         exception_reg;
  logic         ready_reg;

  // Update the visible result only for valid operations; ready is a 1-cycle pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      product_reg   <= '0;
      exception_reg <= 1'b0;
      ready_reg     <= 1'b0;
    end else begin
      ready_reg <= valid_s3_reg;
      if (valid_s3_reg) begin
        product_reg   <= product_next;
        exception_reg <= exception_next;
      end
    end
  end

  assign bus.data_product   = product_reg;
  assign bus.data_result    = product_reg[WIDTH-1:0];
  assign bus.data_exception = exception_reg;
  assign bus.data_resultRDY = ready_reg;

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Bench for wallace_mult_pipe: a WIDTH=4 instance (tables + exhaustive sweep)
// and a WIDTH=32 instance (tables, random, mixed mode, reset mid-flight).
// Expected results are queued at issue and compared when ready pulses.
module tb_wallace_mult_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wallace_mult_pipe_if #(.WIDTH(4))  if4 ();
  wallace_mult_pipe_if #(.WIDTH(32)) if32 ();

  wallace_mult_pipe #(.WIDTH(4)) dut4 (
    .clock (clk),
    .reset (rst),
    .bus   (if4)
  );

  wallace_mult_pipe #(.WIDTH(32)) dut32 (
    .clock (clk),
    .reset (rst),
    .bus   (if32)
  );

  typedef struct {
    logic [63:0] prod;
    logic        exc;
    int          issue;
  } exp_t;

  typedef struct {
    logic       sgn;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] prod;
    logic       exc;
  } vec4_t;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
    logic        exc;
  } vec32_t;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic rst_q  = 1'b0;

  exp_t q4[$];
  exp_t q32[$];
  logic [63:0] last_prod [2];
  logic        last_exc  [2];
  int          rdy_cnt   [2];
  int          run       [2];
  int          max_run   [2];

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic void model4(input logic s, input logic [3:0] a, input logic [3:0] b,
                                 output logic [7:0] p, output logic e);
    int ia, ib, pr;
    ia = int'(a);
    ib = int'(b);
    if (s && a[3]) ia = ia - 16;
    if (s && b[3]) ib = ib - 16;
    pr = ia * ib;
    p  = pr[7:0];
    e  = s ? (pr < -8 || pr > 7) : (pr > 15);
  endfunction

  function automatic void model32(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [63:0] p, output logic e);
    longint ia, ib, pr;
    ia = longint'({{32{s & a[31]}}, a});
    ib = longint'({{32{s & b[31]}}, b});
    pr = ia * ib;
    p  = pr;
    if (s) e = (pr < -longint'(64'h80000000)) || (pr > longint'(64'h7FFFFFFF));
    else   e = (p[63:32] != 32'd0);
  endfunction

  // Per-cycle monitor for one instance: reset state, scoreboard pop, or hold.
  task automatic mon(input int u, input logic rdy, input logic [63:0] prod,
                     input logic [31:0] res, input logic exc);
    exp_t        e;
    logic [31:0] mask;
    string       tag;
    bit          empty;
    mask = (u == 0) ? 32'hF : 32'hFFFF_FFFF;
    tag  = (u == 0) ? "w4" : "w32";
    if (rdy) begin
      rdy_cnt[u]++;
      run[u]++;
      if (run[u] > max_run[u]) max_run[u] = run[u];
    end else begin
      run[u] = 0;
    end
    if (rst_q) begin
      if (u == 0) begin
        while (q4.size() > 0 && q4[0].issue <= cyc) void'(q4.pop_front());
      end else begin
        while (q32.size() > 0 && q32[0].issue <= cyc) void'(q32.pop_front());
      end
      last_prod[u] = '0;
      last_exc[u]  = 1'b0;
      chk($sformatf("%s reset rdy", tag), 64'(rdy), 64'd0);
      chk($sformatf("%s reset product", tag), prod, 64'd0);
      chk($sformatf("%s reset result", tag), 64'(res), 64'd0);
      chk($sformatf("%s reset exception", tag), 64'(exc), 64'd0);
    end else if (rdy) begin
      empty = (u == 0) ? (q4.size() == 0) : (q32.size() == 0);
      if (empty) begin
        checks++;
        failures++;
        $display("FAIL %s spurious rdy: got product %h want no result (cycle %0d)", tag, prod, cyc);
      end else begin
        e = (u == 0) ? q4.pop_front() : q32.pop_front();
        chk($sformatf("%s product", tag), prod, e.prod);
        chk($sformatf("%s result", tag), 64'(res), 64'(e.prod[31:0] & mask));
        chk($sformatf("%s exception", tag), 64'(exc), 64'(e.exc));
        chk($sformatf("%s latency", tag), 64'(cyc), 64'(e.issue + 3));
        last_prod[u] = e.prod;
        last_exc[u]  = e.exc;
      end
    end else begin
      chk($sformatf("%s hold product", tag), prod, last_prod[u]);
      chk($sformatf("%s hold result", tag), 64'(res), 64'(last_prod[u][31:0] & mask));
      chk($sformatf("%s hold exception", tag), 64'(exc), 64'(last_exc[u]));
    end
  endtask

  // Sample both instances on the falling edge, away from the active edge.
  always @(negedge clk) begin
    mon(0, if4.data_resultRDY, 64'(if4.data_product), 32'(if4.data_result), if4.data_exception);
    mon(1, if32.data_resultRDY, if32.data_product, if32.data_result, if32.data_exception);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    if4.ctrl_MULT  = 1'b0;
    if32.ctrl_MULT = 1'b0;
    repeat (n) step();
  endtask

  task automatic issue4(input logic s, input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] p, input logic e);
    exp_t x;
    if4.ctrl_MULT     = 1'b1;
    if4.ctrl_signed   = s;
    if4.data_operandA = a;
    if4.data_operandB = b;
    if32.ctrl_MULT    = 1'b0;
    x.prod  = 64'(p);
    x.exc   = e;
    x.issue = cyc + 1;
    q4.push_back(x);
    $display("issue w4  s=%0d a=%h b=%h expect=%h exc=%0d", s, a, b, p, e);
    step();
  endtask

  task automatic issue32(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] p, input logic e);
    exp_t x;
    if32.ctrl_MULT     = 1'b1;
    if32.ctrl_signed   = s;
    if32.data_operandA = a;
    if32.data_operandB = b;
    if4.ctrl_MULT      = 1'b0;
    x.prod  = p;
    x.exc   = e;
    x.issue = cyc + 1;
    q32.push_back(x);
    $display("issue w32 s=%0d a=%h b=%h expect=%h exc=%0d", s, a, b, p, e);
    step();
  endtask

  vec4_t  tbl4  [0:6];
  vec32_t tbl32 [0:6];

  initial begin
    logic [7:0]  p4;
    logic [63:0] p32;
    logic        ex;
    logic        s;
    logic [31:0] ra, rb;
    int          base;

    tbl4[0] = '{1'b1, 4'h8, 4'h8, 8'h40, 1'b1};
    tbl4[1] = '{1'b1, 4'h3, 4'hE, 8'hFA, 1'b0};
    tbl4[2] = '{1'b0, 4'hF, 4'hF, 8'hE1, 1'b1};
    tbl4[3] = '{1'b0, 4'h3, 4'h5, 8'h0F, 1'b0};
    tbl4[4] = '{1'b1, 4'h7, 4'h7, 8'h31, 1'b1};
    tbl4[5] = '{1'b1, 4'h8, 4'h7, 8'hC8, 1'b1};
    tbl4[6] = '{1'b1, 4'hF, 4'h8, 8'h08, 1'b1};

    tbl32[0] = '{1'b1, 32'h7FFFFFFF, 32'd2,        64'h00000000_FFFFFFFE, 1'b1};
    tbl32[1] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 1'b0};
    tbl32[2] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b1};
    tbl32[3] = '{1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b1};
    tbl32[4] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b1};
    tbl32[5] = '{1'b0, 32'h00000000, 32'hFFFFFFFF, 64'h00000000_00000000, 1'b0};
    tbl32[6] = '{1'b1, 32'hFFFF8000, 32'h00010000, 64'hFFFFFFFF_80000000, 1'b0};

    for (int u = 0; u < 2; u++) begin
      last_prod[u] = '0;
      last_exc[u]  = 1'b0;
      rdy_cnt[u]   = 0;
      run[u]       = 0;
      max_run[u]   = 0;
    end

    // Reset held for two edges with live issue requests: all must be dropped.
    rst = 1'b1;
    if4.ctrl_MULT      = 1'b1;
    if4.ctrl_signed    = 1'b1;
    if4.data_operandA  = 4'h7;
    if4.data_operandB  = 4'h5;
    if32.ctrl_MULT     = 1'b1;
    if32.ctrl_signed   = 1'b0;
    if32.data_operandA = 32'h12345678;
    if32.data_operandB = 32'h9ABCDEF0;
    repeat (2) step();
    rst = 1'b0;
    idle(5);
    chk("w4 no rdy after reset", 64'(rdy_cnt[0]), 64'd0);
    chk("w32 no rdy after reset", 64'(rdy_cnt[1]), 64'd0);

    // Directed tables, back-to-back issues.
    for (int i = 0; i < 7; i++) issue4(tbl4[i].sgn, tbl4[i].a, tbl4[i].b, tbl4[i].prod, tbl4[i].exc);
    for (int i = 0; i < 7; i++) issue32(tbl32[i].sgn, tbl32[i].a, tbl32[i].b, tbl32[i].prod, tbl32[i].exc);
    idle(4);

    // Exhaustive WIDTH=4, signed then unsigned, one issue per cycle.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        model4(1'b1, 4'(a), 4'(b), p4, ex);
        issue4(1'b1, 4'(a), 4'(b), p4, ex);
      end
    end
    idle(4);
    max_run[0] = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        model4(1'b0, 4'(a), 4'(b), p4, ex);
        issue4(1'b0, 4'(a), 4'(b), p4, ex);
      end
    end
    idle(4);
    chk("w4 unsigned rdy run", 64'(max_run[0]), 64'd256);

    // Random WIDTH=32 traffic with mixed modes and occasional gaps.
    for (int i = 0; i < 40; i++) begin
      s  = 1'($urandom_range(0, 1));
      ra = $urandom();
      rb = $urandom();
      model32(s, ra, rb, p32, ex);
      issue32(s, ra, rb, p32, ex);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(4);

    // Alternating signed/unsigned with idle gaps; monitor checks the hold.
    for (int k = 0; k < 3; k++) begin
      issue32(1'b1, 32'hFFFFFFFF, 32'd2, 64'hFFFFFFFF_FFFFFFFE, 1'b0);
      idle(4);
      issue32(1'b0, 32'hFFFFFFFF, 32'd2, 64'h00000001_FFFFFFFE, 1'b1);
      idle(4);
    end

    // Reset with three operations in flight: none may complete.
    for (int i = 0; i < 3; i++) begin
      ra = $urandom();
      rb = $urandom();
      model32(1'b0, ra, rb, p32, ex);
      issue32(1'b0, ra, rb, p32, ex);
    end
    base = rdy_cnt[1];
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(5);
    chk("w32 rdy after mid-flight reset", 64'(rdy_cnt[1] - base), 64'd0);
    chk("w32 queue flushed by reset", 64'(q32.size()), 64'd0);
    issue32(1'b1, 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFF_FFFFFFEB, 1'b0);
    idle(6);

    chk("w4 results outstanding", 64'(q4.size()), 64'd0);
    chk("w32 results outstanding", 64'(q32.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
